quad_decoder: RTL



---
 rtl/quad_pkg.sv | 46 ++++
 rtl/quad_glitch_filter.sv | 46 ++++
 rtl/quad_decoder.sv | 106 ++++++++++
 3 files changed

// File: rtl/quad_pkg.sv
// Shared types and helpers for the quadrature decoder: the {a,b} state encoding,
// the decode-mode constants and the transition classifier.
package quad_pkg;

    typedef enum logic [1:0] {
        Q00 = 2'b00,
        Q10 = 2'b10,
        Q11 = 2'b11,
        Q01 = 2'b01
    } quad_state_t;

    typedef enum logic [1:0] {
        MV_NONE,
        MV_UP,
        MV_DOWN,
        MV_ILLEGAL
    } quad_move_t;

    localparam int DEC_X1 = 1;
    localparam int DEC_X2 = 2;
    localparam int DEC_X4 = 4;

    // Successor along the up sequence 00->10->11->01->00 (A leads B).
    function automatic quad_state_t next_up(input quad_state_t s);
        case (s)
            Q00:     return Q10;
            Q10:     return Q11;
            Q11:     return Q01;
            default: return Q00;
        endcase
    endfunction

    function automatic quad_move_t classify(input quad_state_t prev, input quad_state_t next);
        logic [1:0] diff;
        diff = prev ^ next;
        if (diff == 2'b00)
            return MV_NONE;
        else if (diff == 2'b11)
            return MV_ILLEGAL;
        else if (next == next_up(prev))
            return MV_UP;
        else
            return MV_DOWN;
    endfunction

endpackage

// File: rtl/quad_glitch_filter.sv
// One encoder channel: multi-flop synchroniser followed by a stability counter
// that accepts a new level only after FILTER_CYCLES consecutive mismatches.
module quad_glitch_filter #(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    input  logic active,
    input  logic load,
    output logic synced,
    output logic filtered
);

    localparam logic [3:0] CNT_LAST = 4'(FILTER_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [3:0]             cnt;

    assign synced = sync_q[SYNC_STAGES-1];

    // NOTE: non-blocking assignments make every flop here sample pre-edge values,
    // so the shift chain and the counter/filtered pair stay in lockstep.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q   <= '0;
            cnt      <= '0;
            filtered <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
            if (load) begin
                filtered <= synced;
                cnt      <= '0;
            end else if (!active || synced == filtered) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                filtered <= ~filtered;
                cnt      <= '0;
            end else begin
                cnt <= cnt + 4'd1;
            end
        end
    end

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: primes from the synchronised inputs after reset, then turns
// filtered A/B transitions into step/dir pulses for the up/down counter, flagging illegal jumps.
module quad_decoder
    import quad_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4,
    parameter int DECODE_X      = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic enc_a,
    input  logic enc_b,
    input  logic en,
    input  logic err_clr,
    output logic step,
    output logic dir,
    output logic err
);

    localparam logic [2:0] PRIME_LAST = 3'(SYNC_STAGES);

    logic       sync_a, sync_b;
    logic       filt_a, filt_b;
    logic       primed;
    logic [2:0] prime_cnt;
    logic       load;
    logic [1:0] prev_ab;
    logic [1:0] filt_ab;
    quad_move_t move;
    logic       selected;

    // Filtered state is loaded straight from the synchronisers once the chain has flushed.
    assign load    = !primed && (prime_cnt == PRIME_LAST);
    assign filt_ab = {filt_a, filt_b};
    assign move    = classify(quad_state_t'(prev_ab), quad_state_t'(filt_ab));

    quad_glitch_filter #(
        .SYNC_STAGES  (SYNC_STAGES),
        .FILTER_CYCLES(FILTER_CYCLES)
    ) u_filt_a (
        .clk     (clk),
        .reset   (reset),
        .raw     (enc_a),
        .active  (primed),
        .load    (load),
        .synced  (sync_a),
        .filtered(filt_a)
    );

    quad_glitch_filter #(
        .SYNC_STAGES  (SYNC_STAGES),
        .FILTER_CYCLES(FILTER_CYCLES)
    ) u_filt_b (
        .clk     (clk),
        .reset   (reset),
        .raw     (enc_b),
        .active  (primed),
        .load    (load),
        .synced  (sync_b),
        .filtered(filt_b)
    );

    // Which legal transitions produce a count at the chosen resolution.
    always_comb begin
        selected = 1'b1;
        if (DECODE_X == DEC_X2)
            selected = (prev_ab[1] != filt_ab[1]);
        else if (DECODE_X == DEC_X1)
            selected = (prev_ab == Q00 && filt_ab == Q10) || (prev_ab == Q10 && filt_ab == Q00);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            primed    <= 1'b0;
            prime_cnt <= '0;
            prev_ab   <= Q00;
            step      <= 1'b0;
            dir       <= 1'b1;
            err       <= 1'b0;
        end else begin
            // NOTE: step defaults low every edge, which is what keeps it a one-cycle pulse.
            step <= 1'b0;
            if (!primed) begin
                if (load) begin
                    primed  <= 1'b1;
                    prev_ab <= {sync_a, sync_b};
                end else begin
                    prime_cnt <= prime_cnt + 3'd1;
                end
            end else begin
                prev_ab <= filt_ab;
                if (move == MV_UP || move == MV_DOWN) begin
                    dir  <= (move == MV_UP);
                    step <= en && selected;
                end
            end

            if (primed && move == MV_ILLEGAL)
                err <= 1'b1;
            else if (err_clr)
                err <= 1'b0;
        end
    end

endmodule
